// File: rtl/pio_reg_arb_pkg.sv
// Shared types and constants for the two-requester PIO register arbiter.
package pio_reg_arb_pkg;

  localparam int unsigned DEF_TIMEOUT      = 1024;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEAD_BEEF;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RD_BE_W = 4;
  localparam int unsigned WR_BE_W = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned N_REQ   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_HOLD = 2'd2
  } state_e;

  typedef logic req_idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [RD_BE_W-1:0] be;
  } rd_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [WR_BE_W-1:0] be;
    logic [DATA_W-1:0]  data;
  } wr_req_t;

  // Round-robin: on a tie the requester not granted last wins.
  function automatic req_idx_t rr_pick(input logic [1:0] req, input req_idx_t last);
    if (req[0] && req[1]) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/pio_reg_arbiter_if.sv
// Requester and target signal bundle of the PIO register arbiter.
interface pio_reg_arbiter_if;
  import pio_reg_arb_pkg::*;

  logic                r0_rd_en;
  logic [ADDR_W-1:0]   r0_rd_addr;
  logic [RD_BE_W-1:0]  r0_rd_be;
  logic [DATA_W-1:0]   r0_rd_data;
  logic                r0_rd_data_valid;
  logic                r0_wr_en;
  logic [ADDR_W-1:0]   r0_wr_addr;
  logic [WR_BE_W-1:0]  r0_wr_be;
  logic [DATA_W-1:0]   r0_wr_data;
  logic                r0_wr_busy;

  logic                r1_rd_en;
  logic [ADDR_W-1:0]   r1_rd_addr;
  logic [RD_BE_W-1:0]  r1_rd_be;
  logic [DATA_W-1:0]   r1_rd_data;
  logic                r1_rd_data_valid;
  logic                r1_wr_en;
  logic [ADDR_W-1:0]   r1_wr_addr;
  logic [WR_BE_W-1:0]  r1_wr_be;
  logic [DATA_W-1:0]   r1_wr_data;
  logic                r1_wr_busy;

  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [RD_BE_W-1:0]  rd_be;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_data_valid;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WR_BE_W-1:0]  wr_be;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_busy;
  logic                timeout_err;

  // Arbiter side
  modport master (
    input  r0_rd_en, r0_rd_addr, r0_rd_be, r0_wr_en, r0_wr_addr, r0_wr_be, r0_wr_data,
    input  r1_rd_en, r1_rd_addr, r1_rd_be, r1_wr_en, r1_wr_addr, r1_wr_be, r1_wr_data,
    output r0_rd_data, r0_rd_data_valid, r0_wr_busy,
    output r1_rd_data, r1_rd_data_valid, r1_wr_busy,
    output rd_en, rd_addr, rd_be, wr_en, wr_addr, wr_be, wr_data, timeout_err,
    input  rd_data, rd_data_valid, wr_busy
  );

  // Requester/target environment side
  modport slave (
    output r0_rd_en, r0_rd_addr, r0_rd_be, r0_wr_en, r0_wr_addr, r0_wr_be, r0_wr_data,
    output r1_rd_en, r1_rd_addr, r1_rd_be, r1_wr_en, r1_wr_addr, r1_wr_be, r1_wr_data,
    input  r0_rd_data, r0_rd_data_valid, r0_wr_busy,
    input  r1_rd_data, r1_rd_data_valid, r1_wr_busy,
    input  rd_en, rd_addr, rd_be, wr_en, wr_addr, wr_be, wr_data, timeout_err,
    output rd_data, rd_data_valid, wr_busy
  );

endinterface

// File: rtl/pio_reg_arb_slot.sv
// One-deep request capture: loads when empty, drops loads while full.
module pio_reg_arb_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;

  // A clear also cancels a load arriving in the same cycle (bypassed grant).
  assign full_d = (full_q | load_i) & ~clear_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (load_i && !full_q) data_q <= data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/pio_reg_arbiter.sv
// Arbitrates PCIe PIO (r0) and local (r1) register accesses onto one target port.
module pio_reg_arbiter
  import pio_reg_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter logic [31:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
  input  logic               clk,
  input  logic               rst_n,
  pio_reg_arbiter_if.master  bus
);

  logic [N_REQ-1:0] rd_ld, wr_ld, rd_clr, wr_clr, rd_full, wr_full;
  logic [N_REQ-1:0] rd_vld_c, wr_vld_c, req_c;
  rd_req_t          rd_in [N_REQ];
  rd_req_t          rd_q  [N_REQ];
  rd_req_t          rd_c  [N_REQ];
  wr_req_t          wr_in [N_REQ];
  wr_req_t          wr_q  [N_REQ];
  wr_req_t          wr_c  [N_REQ];

  state_e             state_q;
  req_idx_t           gnt_q, last_q, pick_c;
  logic [CNT_W-1:0]   cnt_q;
  logic               go_c, use_wr_c;
  logic               rd_en_q, wr_en_q, tmo_q;
  logic [ADDR_W-1:0]  rd_addr_q, wr_addr_q;
  logic [RD_BE_W-1:0] rd_be_q;
  logic [WR_BE_W-1:0] wr_be_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [DATA_W-1:0]  rsp_data_q [N_REQ];
  logic [N_REQ-1:0]   rsp_vld_q;

  assign rd_ld[0] = bus.r0_rd_en;
  assign rd_ld[1] = bus.r1_rd_en;
  assign wr_ld[0] = bus.r0_wr_en;
  assign wr_ld[1] = bus.r1_wr_en;
  assign rd_in[0] = {bus.r0_rd_addr, bus.r0_rd_be};
  assign rd_in[1] = {bus.r1_rd_addr, bus.r1_rd_be};
  assign wr_in[0] = {bus.r0_wr_addr, bus.r0_wr_be, bus.r0_wr_data};
  assign wr_in[1] = {bus.r1_wr_addr, bus.r1_wr_be, bus.r1_wr_data};

  // Per-requester read and write slots; requests arriving this cycle are
  // visible to the arbiter immediately so an idle read reaches rd_en next cycle.
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    pio_reg_arb_slot #(.W($bits(rd_req_t))) u_rd_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (rd_ld[g]),
      .clear_i (rd_clr[g]),
      .data_i  (rd_in[g]),
      .full_o  (rd_full[g]),
      .data_o  (rd_q[g])
    );

    pio_reg_arb_slot #(.W($bits(wr_req_t))) u_wr_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (wr_ld[g]),
      .clear_i (wr_clr[g]),
      .data_i  (wr_in[g]),
      .full_o  (wr_full[g]),
      .data_o  (wr_q[g])
    );

    assign rd_vld_c[g] = rd_full[g] | rd_ld[g];
    assign wr_vld_c[g] = wr_full[g] | wr_ld[g];
    assign rd_c[g]     = rd_full[g] ? rd_q[g] : rd_in[g];
    assign wr_c[g]     = wr_full[g] ? wr_q[g] : wr_in[g];
    assign req_c[g]    = rd_vld_c[g] | wr_vld_c[g];
  end

  // Grant selection and slot release
  always_comb begin
    pick_c   = rr_pick(req_c, last_q);
    go_c     = (state_q == IDLE) && (|req_c);
    use_wr_c = wr_vld_c[pick_c];
    rd_clr   = '0;
    wr_clr   = '0;
    if (go_c && !use_wr_c) rd_clr[pick_c] = 1'b1;
    if ((state_q == WR_HOLD) && !bus.wr_busy) wr_clr[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= 1'b0;
      last_q        <= 1'b1;
      cnt_q         <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      rd_be_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_be_q       <= '0;
      wr_data_q     <= '0;
      tmo_q         <= 1'b0;
      rsp_vld_q     <= '0;
      rsp_data_q[0] <= '0;
      rsp_data_q[1] <= '0;
    end else begin
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      tmo_q     <= 1'b0;
      rsp_vld_q <= '0;
      case (state_q)
        IDLE: begin
          if (go_c) begin
            gnt_q  <= pick_c;
            last_q <= pick_c;
            cnt_q  <= '0;
            if (use_wr_c) begin
              state_q   <= WR_HOLD;
              wr_addr_q <= wr_c[pick_c].addr;
              wr_be_q   <= wr_c[pick_c].be;
              wr_data_q <= wr_c[pick_c].data;
            end else begin
              state_q   <= RD_WAIT;
              rd_en_q   <= 1'b1;
              rd_addr_q <= rd_c[pick_c].addr;
              rd_be_q   <= rd_c[pick_c].be;
            end
          end
        end
        RD_WAIT: begin
          // cnt_q counts elapsed wait cycles; the final one completes with TIMEOUT_DATA.
          if (bus.rd_data_valid) begin
            rsp_data_q[gnt_q] <= bus.rd_data;
            rsp_vld_q[gnt_q]  <= 1'b1;
            state_q           <= IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_data_q[gnt_q] <= TIMEOUT_DATA;
            rsp_vld_q[gnt_q]  <= 1'b1;
            tmo_q             <= 1'b1;
            state_q           <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WR_HOLD: begin
          if (!bus.wr_busy) begin
            wr_en_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_en            = rd_en_q;
  assign bus.rd_addr          = rd_addr_q;
  assign bus.rd_be            = rd_be_q;
  assign bus.wr_en            = wr_en_q;
  assign bus.wr_addr          = wr_addr_q;
  assign bus.wr_be            = wr_be_q;
  assign bus.wr_data          = wr_data_q;
  assign bus.timeout_err      = tmo_q;
  assign bus.r0_rd_data       = rsp_data_q[0];
  assign bus.r1_rd_data       = rsp_data_q[1];
  assign bus.r0_rd_data_valid = rsp_vld_q[0];
  assign bus.r1_rd_data_valid = rsp_vld_q[1];
  assign bus.r0_wr_busy       = wr_full[0] | ((state_q == WR_HOLD) && (gnt_q == 1'b0));
  assign bus.r1_wr_busy       = wr_full[1] | ((state_q == WR_HOLD) && (gnt_q == 1'b1));

endmodule

// File: tb/tb_pio_reg_arbiter.sv
// Directed bench for pio_reg_arbiter with hand-computed expectations.
module tb_pio_reg_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pio_reg_arbiter_if bus ();

  pio_reg_arbiter #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.r0_rd_en = 0; bus.r0_rd_addr = '0; bus.r0_rd_be = '0;
    bus.r0_wr_en = 0; bus.r0_wr_addr = '0; bus.r0_wr_be = '0; bus.r0_wr_data = '0;
    bus.r1_rd_en = 0; bus.r1_rd_addr = '0; bus.r1_rd_be = '0;
    bus.r1_wr_en = 0; bus.r1_wr_addr = '0; bus.r1_wr_be = '0; bus.r1_wr_data = '0;
    bus.rd_data = '0; bus.rd_data_valid = 0; bus.wr_busy = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", bus.rd_en); end
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    total++; if (bus.rd_addr !== 32'h0) begin bad++; $display("FAIL reset_rd_addr got=%h exp=0", bus.rd_addr); end
    total++; if (bus.r0_wr_busy !== 1'b0 || bus.r1_wr_busy !== 1'b0) begin bad++; $display("FAIL reset_wr_busy got=%b%b exp=00", bus.r0_wr_busy, bus.r1_wr_busy); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout_err); end
  endtask

  task automatic test_single_read();
    bus.r0_rd_en = 1; bus.r0_rd_addr = 32'h0000_0010; bus.r0_rd_be = 4'hF;
    tick();
    bus.r0_rd_en = 0;
    total++; if (bus.rd_en !== 1'b1) begin bad++; $display("FAIL rd_latency got=%b exp=1", bus.rd_en); end
    total++; if (bus.rd_addr !== 32'h10 || bus.rd_be !== 4'hF) begin bad++; $display("FAIL rd_addr_be got=%h/%h exp=10/f", bus.rd_addr, bus.rd_be); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.rd_en !== 1'b0 || bus.r0_rd_data_valid !== 1'b0) begin bad++; $display("FAIL rd_wait_%0d got=%b%b exp=00", i, bus.rd_en, bus.r0_rd_data_valid); end
    end
    bus.rd_data = 32'h1234_5678; bus.rd_data_valid = 1;
    tick();
    bus.rd_data_valid = 0;
    total++; if (bus.r0_rd_data_valid !== 1'b1 || bus.r0_rd_data !== 32'h1234_5678) begin bad++; $display("FAIL rd_complete got=%b/%h exp=1/12345678", bus.r0_rd_data_valid, bus.r0_rd_data); end
    total++; if (bus.r1_rd_data_valid !== 1'b0) begin bad++; $display("FAIL rd_r1_quiet got=%b exp=0", bus.r1_rd_data_valid); end
    tick();
    total++; if (bus.r0_rd_data_valid !== 1'b0) begin bad++; $display("FAIL rd_one_pulse got=%b exp=0", bus.r0_rd_data_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.r0_rd_en = 1; bus.r0_rd_addr = 32'h100; bus.r0_rd_be = 4'h3;
    bus.r1_rd_en = 1; bus.r1_rd_addr = 32'h200; bus.r1_rd_be = 4'hC;
    tick();
    bus.r0_rd_en = 0; bus.r1_rd_en = 0;
    total++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 32'h100) begin bad++; $display("FAIL sim_r0_first got=%b/%h exp=1/100", bus.rd_en, bus.rd_addr); end
    bus.rd_data = 32'hAAAA_0000; bus.rd_data_valid = 1;
    tick();
    bus.rd_data_valid = 0;
    total++; if (bus.r0_rd_data_valid !== 1'b1 || bus.r0_rd_data !== 32'hAAAA_0000) begin bad++; $display("FAIL sim_r0_done got=%b/%h exp=1/aaaa0000", bus.r0_rd_data_valid, bus.r0_rd_data); end
    total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL sim_gap got=%b exp=0", bus.rd_en); end
    tick();
    total++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 32'h200 || bus.rd_be !== 4'hC) begin bad++; $display("FAIL sim_r1_next got=%b/%h/%h exp=1/200/c", bus.rd_en, bus.rd_addr, bus.rd_be); end
    bus.rd_data = 32'hBBBB_0000; bus.rd_data_valid = 1;
    tick();
    bus.rd_data_valid = 0;
    total++; if (bus.r1_rd_data_valid !== 1'b1 || bus.r1_rd_data !== 32'hBBBB_0000 || bus.r0_rd_data_valid !== 1'b0) begin bad++; $display("FAIL sim_r1_done got=%b/%h/%b exp=1/bbbb0000/0", bus.r1_rd_data_valid, bus.r1_rd_data, bus.r0_rd_data_valid); end
  endtask

  task automatic test_write_busy();
    bus.wr_busy = 1;
    bus.r1_wr_en = 1; bus.r1_wr_addr = 32'h40; bus.r1_wr_be = 8'hFF; bus.r1_wr_data = 32'hA5A5_A5A5;
    tick();
    bus.r1_wr_en = 0;
    total++; if (bus.wr_addr !== 32'h40 || bus.wr_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wr_payload got=%h/%h exp=40/a5a5a5a5", bus.wr_addr, bus.wr_data); end
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.wr_en !== 1'b0 || bus.r1_wr_busy !== 1'b1 || bus.r0_wr_busy !== 1'b0) begin bad++; $display("FAIL wr_hold_%0d got=%b%b%b exp=010", i, bus.wr_en, bus.r1_wr_busy, bus.r0_wr_busy); end
      if (i == 4) bus.wr_busy = 0;
      tick();
    end
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'h40 || bus.wr_be !== 8'hFF || bus.wr_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wr_strobe got=%b/%h/%h/%h exp=1/40/ff/a5a5a5a5", bus.wr_en, bus.wr_addr, bus.wr_be, bus.wr_data); end
    tick();
    total++; if (bus.wr_en !== 1'b0 || bus.r1_wr_busy !== 1'b0) begin bad++; $display("FAIL wr_single got=%b%b exp=00", bus.wr_en, bus.r1_wr_busy); end
    total++; if (bus.wr_addr !== 32'h40) begin bad++; $display("FAIL wr_addr_hold got=%h exp=40", bus.wr_addr); end
  endtask

  task automatic test_back_to_back();
    bus.r0_rd_en = 1; bus.r0_rd_addr = 32'h500; bus.r0_rd_be = 4'h1;
    tick();
    total++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 32'h500) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/500", bus.rd_en, bus.rd_addr); end
    bus.r0_rd_addr = 32'h504;
    tick();
    bus.r0_rd_addr = 32'h508;
    bus.r0_wr_en = 1; bus.r0_wr_addr = 32'h600; bus.r0_wr_be = 8'h0F; bus.r0_wr_data = 32'h1111_2222;
    tick();
    bus.r0_rd_en = 0; bus.r0_wr_en = 0;
    total++; if (bus.r0_wr_busy !== 1'b1) begin bad++; $display("FAIL b2b_wr_busy got=%b exp=1", bus.r0_wr_busy); end
    bus.rd_data = 32'hCAFE_0001; bus.rd_data_valid = 1;
    tick();
    bus.rd_data_valid = 0;
    total++; if (bus.r0_rd_data_valid !== 1'b1 || bus.r0_rd_data !== 32'hCAFE_0001) begin bad++; $display("FAIL b2b_done got=%b/%h exp=1/cafe0001", bus.r0_rd_data_valid, bus.r0_rd_data); end
    tick();
    total++; if (bus.rd_en !== 1'b0 || bus.wr_addr !== 32'h600) begin bad++; $display("FAIL b2b_wr_first got=%b/%h exp=0/600", bus.rd_en, bus.wr_addr); end
    tick();
    total++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h1111_2222 || bus.wr_be !== 8'h0F) begin bad++; $display("FAIL b2b_wr got=%b/%h/%h exp=1/11112222/0f", bus.wr_en, bus.wr_data, bus.wr_be); end
    tick();
    total++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 32'h504) begin bad++; $display("FAIL b2b_second_rd got=%b/%h exp=1/504", bus.rd_en, bus.rd_addr); end
    bus.rd_data = 32'hCAFE_0002; bus.rd_data_valid = 1;
    tick();
    bus.rd_data_valid = 0;
    total++; if (bus.r0_rd_data_valid !== 1'b1 || bus.r0_rd_data !== 32'hCAFE_0002) begin bad++; $display("FAIL b2b_second_done got=%b/%h exp=1/cafe0002", bus.r0_rd_data_valid, bus.r0_rd_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL b2b_dropped_%0d got=%b exp=0", i, bus.rd_en); end
    end
  endtask

  task automatic test_timeout();
    bus.r0_rd_en = 1; bus.r0_rd_addr = 32'h80; bus.r0_rd_be = 4'hF;
    tick();
    bus.r0_rd_en = 0;
    total++; if (bus.rd_en !== 1'b1) begin bad++; $display("FAIL tmo_rd_en got=%b exp=1", bus.rd_en); end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++; if (bus.timeout_err !== 1'b0 || bus.r0_rd_data_valid !== 1'b0) begin bad++; $display("FAIL tmo_early_%0d got=%b%b exp=00", i, bus.timeout_err, bus.r0_rd_data_valid); end
    end
    tick();
    total++; if (bus.timeout_err !== 1'b1 || bus.r0_rd_data_valid !== 1'b1 || bus.r0_rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tmo_fire got=%b/%b/%h exp=1/1/deadbeef", bus.timeout_err, bus.r0_rd_data_valid, bus.r0_rd_data); end
    bus.rd_data = 32'h5555_5555; bus.rd_data_valid = 1;
    tick();
    bus.rd_data_valid = 0;
    total++; if (bus.timeout_err !== 1'b0 || bus.r0_rd_data_valid !== 1'b0 || bus.r0_rd_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL tmo_late_ignored got=%b/%b/%h exp=0/0/deadbeef", bus.timeout_err, bus.r0_rd_data_valid, bus.r0_rd_data); end
  endtask

  task automatic test_reset_mid_read();
    bus.r0_rd_en = 1; bus.r0_rd_addr = 32'hC0; bus.r0_rd_be = 4'h7;
    tick();
    bus.r0_rd_en = 0;
    total++; if (bus.rd_en !== 1'b1) begin bad++; $display("FAIL rst_mid_rd_en got=%b exp=1", bus.rd_en); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.rd_addr !== 32'h0 || bus.rd_be !== 4'h0 || bus.wr_addr !== 32'h0) begin bad++; $display("FAIL rst_async_tgt got=%h/%h/%h exp=0/0/0", bus.rd_addr, bus.rd_be, bus.wr_addr); end
    total++; if (bus.r0_rd_data !== 32'h0) begin bad++; $display("FAIL rst_async_rsp got=%h exp=0", bus.r0_rd_data); end
    bus.rd_data = 32'h7777_7777; bus.rd_data_valid = 1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.r0_rd_data_valid !== 1'b0 || bus.rd_en !== 1'b0) begin bad++; $display("FAIL rst_no_completion_%0d got=%b%b exp=00", i, bus.r0_rd_data_valid, bus.rd_en); end
    end
    bus.rd_data_valid = 0;
    bus.r1_rd_en = 1; bus.r1_rd_addr = 32'h300; bus.r1_rd_be = 4'hF;
    tick();
    bus.r1_rd_en = 0;
    total++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 32'h300) begin bad++; $display("FAIL rst_next_rd got=%b/%h exp=1/300", bus.rd_en, bus.rd_addr); end
    bus.rd_data = 32'h0BAD_F00D; bus.rd_data_valid = 1;
    tick();
    bus.rd_data_valid = 0;
    total++; if (bus.r1_rd_data_valid !== 1'b1 || bus.r1_rd_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL rst_next_done got=%b/%h exp=1/0badf00d", bus.r1_rd_data_valid, bus.r1_rd_data); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write_busy();
    test_back_to_back();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
